// File: rtl/fpga_sys_reset_ctrl.sv
// SYSCLK-domain reset sequencer for the Cortex-M subsystem.
// Sequences PORESETn then HRESETn after the synchronised board reset releases,
// stretches runtime reset requests into system-only resets, and keeps a sticky
// reset-cause register for software.
module fpga_sys_reset_ctrl #(
    parameter int unsigned POR_HOLD_CYCLES = 16,
    parameter int unsigned SYS_HOLD_CYCLES = 8,
    parameter int unsigned LOCKUP_RESET_EN = 1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       SYSCLK,
    input  logic       RST_SYSCLK,
    input  logic       SYSRESETREQ,
    input  logic       WDOG_RESET_REQ,
    input  logic       LOCKUP,
    input  logic       CAUSE_CLR,
    output logic       PORESETn,
    output logic       HRESETn,
    output logic [3:0] RST_CAUSE,
    output logic       RST_BUSY
);

    typedef enum logic [1:0] {
        POR_HOLD = 2'd0,
        SYS_HOLD = 2'd1,
        RUN      = 2'd2,
        REQ_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             poresetn_q, poresetn_d;
    logic             hresetn_q, hresetn_d;
    logic [3:0]       cause_q, cause_d;
    logic             busy_q, busy_d;

    logic             lockup_req;
    logic             req;
    logic [3:0]       new_bits;

    // Runtime request decode; bit0 (POR) is never set by a runtime request.
    always_comb begin
        lockup_req = LOCKUP & (LOCKUP_RESET_EN != 0);
        req        = SYSRESETREQ | WDOG_RESET_REQ | lockup_req;
        new_bits   = {lockup_req, WDOG_RESET_REQ, SYSRESETREQ, 1'b0};
    end

    // State and output registers; board reset overrides everything.
    always_ff @(posedge SYSCLK) begin
        if (RST_SYSCLK) begin
            state_q    <= POR_HOLD;
            cnt_q      <= '0;
            poresetn_q <= 1'b0;
            hresetn_q  <= 1'b0;
            cause_q    <= 4'b0001;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poresetn_q <= poresetn_d;
            hresetn_q  <= hresetn_d;
            cause_q    <= cause_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        poresetn_d = poresetn_q;
        hresetn_d  = hresetn_q;
        cause_d    = cause_q;
        busy_d     = busy_q;

        unique case (state_q)
            POR_HOLD: begin
                if (cnt_q == POR_LAST) begin
                    poresetn_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = SYS_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SYS_HOLD: begin
                if (cnt_q == SYS_LAST) begin
                    hresetn_d = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cause_d = (CAUSE_CLR ? 4'b0000 : cause_q) | new_bits;
                if (req) begin
                    hresetn_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ_HOLD;
                end
            end
            REQ_HOLD: begin
                cause_d = (CAUSE_CLR ? 4'b0000 : cause_q) | new_bits;
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q == SYS_LAST) begin
                    hresetn_d = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = POR_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    assign PORESETn  = poresetn_q;
    assign HRESETn   = hresetn_q;
    assign RST_CAUSE = cause_q;
    assign RST_BUSY  = busy_q;

endmodule

// File: tb/tb_fpga_sys_reset_ctrl.sv
// Directed bench for fpga_sys_reset_ctrl: a table of per-edge vectors plus
// hand-written sequences for the long holds and reset interruption.
// A second instance with LOCKUP_RESET_EN=0 shares the same stimulus.
module tb_fpga_sys_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sreq = 1'b0;
    logic       wdog = 1'b0;
    logic       lock = 1'b0;
    logic       clr = 1'b0;

    logic       por0, hres0, busy0;
    logic [3:0] cause0;
    logic       por1, hres1, busy1;
    logic [3:0] cause1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpga_sys_reset_ctrl #(
        .POR_HOLD_CYCLES(16),
        .SYS_HOLD_CYCLES(8),
        .LOCKUP_RESET_EN(1),
        .CNT_W(8)
    ) dut (
        .SYSCLK(clk), .RST_SYSCLK(rst), .SYSRESETREQ(sreq),
        .WDOG_RESET_REQ(wdog), .LOCKUP(lock), .CAUSE_CLR(clr),
        .PORESETn(por0), .HRESETn(hres0), .RST_CAUSE(cause0), .RST_BUSY(busy0)
    );

    fpga_sys_reset_ctrl #(
        .POR_HOLD_CYCLES(16),
        .SYS_HOLD_CYCLES(8),
        .LOCKUP_RESET_EN(0),
        .CNT_W(8)
    ) dut_nolock (
        .SYSCLK(clk), .RST_SYSCLK(rst), .SYSRESETREQ(sreq),
        .WDOG_RESET_REQ(wdog), .LOCKUP(lock), .CAUSE_CLR(clr),
        .PORESETn(por1), .HRESETn(hres1), .RST_CAUSE(cause1), .RST_BUSY(busy1)
    );

    typedef struct {
        logic       rst, sreq, wdog, lock, clr;
        logic       por, hres;
        logic [3:0] cause;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic w, logic l, logic c,
                                logic p, logic h, logic [3:0] ca, logic b);
        vec_t v;
        v.rst = r; v.sreq = s; v.wdog = w; v.lock = l; v.clr = c;
        v.por = p; v.hres = h; v.cause = ca; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic p, input logic h,
                           input logic [3:0] ca, input logic b);
        chk({tag, ".PORESETn"},  {3'b0, por0},  {3'b0, p});
        chk({tag, ".HRESETn"},   {3'b0, hres0}, {3'b0, h});
        chk({tag, ".RST_CAUSE"}, cause0,        ca);
        chk({tag, ".RST_BUSY"},  {3'b0, busy0}, {3'b0, b});
    endtask

    // Advance one SYSCLK edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic s, input logic w,
                          input logic l, input logic c);
        rst = r; sreq = s; wdog = w; lock = l; clr = c;
    endtask

    // Hold reset for nrst edges, then release and follow the 16+8 sequence.
    task automatic por_seq(input int unsigned nrst, input string tag);
        set_in(1, 0, 0, 0, 0);
        for (int unsigned i = 0; i < nrst; i++) begin
            step();
            chk_all({tag, ".rst"}, 0, 0, 4'b0001, 1);
        end
        rst = 1'b0;
        for (int unsigned i = 1; i <= 24; i++) begin
            step();
            chk_all($sformatf("%s.seq%0d", tag, i), (i >= 16), (i >= 24), 4'b0001, (i < 24));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Table: SYSRESETREQ pulse, then CAUSE_CLR alone and with SYSRESETREQ.
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 4'b0011, 1));
        for (int unsigned i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'b0011, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4'b0011, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4'b0011, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4'b0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 4'b0010, 1));
        for (int unsigned i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'b0010, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4'b0010, 0));

        // Power-on sequence with 3 reset edges.
        por_seq(3, "por");

        foreach (tbl[k]) begin
            set_in(tbl[k].rst, tbl[k].sreq, tbl[k].wdog, tbl[k].lock, tbl[k].clr);
            step();
            chk_all($sformatf("vec%0d", k), tbl[k].por, tbl[k].hres, tbl[k].cause, tbl[k].busy);
        end
        set_in(0, 0, 0, 0, 0);

        // Watchdog held 20 edges: HRESETn low throughout, rises on 8th edge after drop.
        wdog = 1'b1;
        for (int unsigned i = 0; i < 20; i++) begin
            step();
            chk_all($sformatf("wdog_hold%0d", i), 1, 0, 4'b0110, 1);
        end
        wdog = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            step();
            chk_all($sformatf("wdog_rel%0d", i), 1, (i == 8), 4'b0110, (i < 8));
        end

        // Watchdog + LOCKUP on the same edge; second instance ignores LOCKUP.
        por_seq(1, "por2");
        set_in(0, 0, 1, 1, 0);
        step();
        chk_all("wdlk", 1, 0, 4'b1101, 1);
        chk("wdlk_nolock.RST_CAUSE", cause1, 4'b0101);
        set_in(0, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 8; i++) step();
        chk_all("wdlk_done", 1, 1, 4'b1101, 0);
        chk("wdlk_done_nolock.HRESETn", {3'b0, hres1}, 4'b0001);

        // LOCKUP alone: reset on enabled instance, ignored on the other.
        lock = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("lock%0d", i), 1, 0, 4'b1101, 1);
            chk($sformatf("lock%0d_nolock.HRESETn", i), {3'b0, hres1}, 4'b0001);
            chk($sformatf("lock%0d_nolock.RST_BUSY", i), {3'b0, busy1}, 4'b0000);
            chk($sformatf("lock%0d_nolock.RST_CAUSE", i), cause1, 4'b0101);
        end
        lock = 1'b0;
        for (int unsigned i = 0; i < 8; i++) step();
        chk_all("lock_done", 1, 1, 4'b1101, 0);

        // RST_SYSCLK during cycle 3 of REQ_HOLD restarts the full sequence.
        sreq = 1'b1;
        step();
        sreq = 1'b0;
        chk_all("rq_enter", 1, 0, 4'b1111, 1);
        step();
        step();
        chk_all("rq_mid", 1, 0, 4'b1111, 1);
        por_seq(1, "por3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
